// File: rtl/strobe_pkg.sv
// Shared types and constants for the strobe FSM bank.
package strobe_pkg;

  localparam int STATE_W = 2;
  localparam int CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_HOLD  = 2'b11,
    ST_DONE  = 2'b10
  } chan_state_e;

endpackage

// File: rtl/strobe_chan.sv
// One strobe channel: IDLE -> ARMED -> HOLD(HOLD_CYC) -> DONE -> IDLE, with capture register.
// Overrun flag storage exists only when STRB_OVF_EN is defined.
module strobe_chan
  import strobe_pkg::*;
#(
  parameter int DW       = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rise,
  input  logic [DW-1:0]      i_data,
  input  logic               i_ovf_clr,
  output logic [STATE_W-1:0] o_state,
  output logic               o_done,
  output logic [DW-1:0]      o_data,
  output logic               o_ovf
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    data_q, data_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE:  if (i_rise) state_d = ST_ARMED;
      ST_ARMED: begin
        data_d  = i_data;
        cnt_d   = CNT_W'(HOLD_CYC - 1);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign o_state = state_q;
  assign o_done  = (state_q == ST_DONE);
  assign o_data  = data_q;

`ifdef STRB_OVF_EN
  logic ovf_q, ovf_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  // A dropped rise outranks a same-cycle clear so no overrun is lost.
  always_comb begin
    ovf_d = ovf_q;
    if (i_ovf_clr)                       ovf_d = 1'b0;
    if (i_rise && (state_q != ST_IDLE)) ovf_d = 1'b1;
  end

  assign o_ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = i_ovf_clr;
  assign o_ovf          = 1'b0;
`endif

endmodule

// File: rtl/strobe_fsm_bank.sv
// Bank of NCH independent strobe-triggered capture FSMs with shared data and a read mux.
// Optional overrun flags enabled by STRB_OVF_EN.
module strobe_fsm_bank
  import strobe_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int LSB_IDX  = -12,
  parameter int DW       = 8,
  parameter int HOLD_CYC = 2,
  localparam int RSW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [LSB_IDX:LSB_IDX+NCH-1] i_strb,
  input  logic [DW-1:0]              i_data,
  input  logic [RSW-1:0]             i_rd_sel,
  input  logic                       i_ovf_clr,
  output logic [2*NCH-1:0]           o_state,
  output logic [NCH-1:0]             o_done,
  output logic                       o_busy,
  output logic [DW-1:0]              o_data,
  output logic [NCH-1:0]             o_ovf
);

  logic [NCH-1:0]              strb_v, strb_q, rise;
  logic [NCH-1:0][STATE_W-1:0] ch_state;
  logic [NCH-1:0][DW-1:0]      ch_data;

  // Remap the ascending strobe range so channel 0 is the bit at LSB_IDX.
  for (genvar k = 0; k < NCH; k++) begin : g_map
    assign strb_v[k] = i_strb[LSB_IDX+k];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) strb_q <= '0;
    else       strb_q <= strb_v;
  end

  assign rise = strb_v & ~strb_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    strobe_chan #(
      .DW       (DW),
      .HOLD_CYC (HOLD_CYC)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_rise    (rise[k]),
      .i_data    (i_data),
      .i_ovf_clr (i_ovf_clr),
      .o_state   (ch_state[k]),
      .o_done    (o_done[k]),
      .o_data    (ch_data[k]),
      .o_ovf     (o_ovf[k])
    );
  end

  assign o_state = ch_state;

  always_comb begin
    o_busy = 1'b0;
    for (int k = 0; k < NCH; k++)
      if (ch_state[k] != ST_IDLE) o_busy = 1'b1;
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < NCH; k++)
      if (i_rd_sel == RSW'(k)) o_data = ch_data[k];
  end

endmodule

// File: tb/tb_strobe_fsm_bank.sv
// Randomized bench for strobe_fsm_bank with a timestamp-based reference model.
module tb_strobe_fsm_bank;
  localparam int NCH = 4, LSB = -12, DW = 8, HC = 2;
  localparam int NEVER = -100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, ovf_clr;
  logic [LSB:LSB+NCH-1] strb;
  logic [DW-1:0]        data, dout;
  logic [1:0]           rd_sel;
  logic [2*NCH-1:0]     st;
  logic [NCH-1:0]       done, ovf;
  logic                 busy;

  logic       rst1, clr1, busy1;
  logic [0:0] strb1, sel1, done1, ovf1;
  logic [7:0] data1, dout1;
  logic [1:0] st1;

  strobe_fsm_bank #(.NCH(NCH), .LSB_IDX(LSB), .DW(DW), .HOLD_CYC(HC)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_strb(strb), .i_data(data), .i_rd_sel(rd_sel),
    .i_ovf_clr(ovf_clr), .o_state(st), .o_done(done), .o_busy(busy),
    .o_data(dout), .o_ovf(ovf)
  );

  strobe_fsm_bank #(.NCH(1), .LSB_IDX(0), .DW(8), .HOLD_CYC(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_strb(strb1), .i_data(data1), .i_rd_sel(sel1),
    .i_ovf_clr(clr1), .o_state(st1), .o_done(done1), .o_busy(busy1),
    .o_data(dout1), .o_ovf(ovf1)
  );

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each channel remembers the edge at which its sequence was accepted.
  int             t = 0;
  int             start [NCH];
  logic [DW-1:0]  mdata [NCH];
  logic [NCH-1:0] mprev, movf;

  function automatic logic [1:0] exp_st(input int k);
    int d;
    d = t - start[k];
    if (d == 0)             return 2'b01;
    if (d >= 1 && d <= HC)  return 2'b11;
    if (d == HC + 1)        return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      start[k] = NEVER;
      mdata[k] = '0;
    end
    mprev = '0;
    movf  = '0;
  endtask

  task automatic model_edge();
    logic r, act;
    t++;
    for (int k = 0; k < NCH; k++) begin
      r   = strb[LSB+k] & ~mprev[k];
      act = (t - 1 - start[k]) <= HC + 1;
`ifdef STRB_OVF_EN
      if (ovf_clr) movf[k] = 1'b0;
      if (r && act) movf[k] = 1'b1;
`endif
      if (r && !act) start[k] = t;
      if (t - start[k] == 1) mdata[k] = data;
      mprev[k] = strb[LSB+k];
    end
  endtask

  task automatic check_all();
    logic [2*NCH-1:0] es;
    logic [NCH-1:0]   ed;
    for (int k = 0; k < NCH; k++) begin
      es[2*k +: 2] = exp_st(k);
      ed[k]        = (exp_st(k) == 2'b10);
    end
    chk("state", 32'(st), 32'(es));
    chk("done", 32'(done), 32'(ed));
    chk("busy", 32'(busy), 32'(es != '0));
    chk("ovf", 32'(ovf), 32'(movf));
    chk("data", 32'(dout), 32'(mdata[rd_sel]));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step();
    rst = 1'b0;
  endtask

  int  ndone;
  logic [3:0] exp_ovf;

  initial begin
    rst = 1'b1; strb = '0; data = '0; rd_sel = '0; ovf_clr = 1'b0;
    rst1 = 1'b1; strb1 = '0; data1 = '0; sel1 = '0; clr1 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0; rst1 = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_state", 32'(st), 32'h0);
    end

    // Single sequence on channel 0
    begin
      logic [1:0] seq [5] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
      strb[-12] = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step();
        if (i == 0) begin strb[-12] = 1'b0; data = 8'hA5; end
        else data = 8'h00;
        chk("s0_state", 32'(st[1:0]), 32'(seq[i]));
        chk("s0_done", 32'(done[0]), 32'(i == 3));
      end
      rd_sel = 2'd0; #1;
      chk("s0_data", 32'(dout), 32'hA5);
    end

    // Simultaneous rises on channels 1 and 3
    strb[-11] = 1'b1; strb[-9] = 1'b1;
    step();
    strb = '0; data = 8'h3C;
    step();
    data = 8'h11;
    step(); step();
    chk("dual_done", 32'(done), 32'hA);
    rd_sel = 2'd1; #1; chk("dual_d1", 32'(dout), 32'h3C);
    rd_sel = 2'd3; #1; chk("dual_d3", 32'(dout), 32'h3C);
    step(); step();

    // Re-strobe during HOLD is dropped
    ndone = 0;
    strb[-12] = 1'b1;
    step();
    strb[-12] = 1'b0;
    step();
    strb[-12] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      strb[-12] = 1'b0;
      if (done[0]) ndone++;
    end
    chk("ovr_pulses", 32'(ndone), 32'd1);
`ifdef STRB_OVF_EN
    exp_ovf = 4'b0001;
`else
    exp_ovf = 4'b0000;
`endif
    chk("ovr_flag", 32'(ovf), 32'(exp_ovf));
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovr_clr", 32'(ovf), 32'h0);

    // Reset mid-HOLD, strobe held through release
    strb[-12] = 1'b1;
    step(); step();
    chk("mid_hold", 32'(st[1:0]), 32'h3);
    do_reset();
    chk("rst_idle", 32'(st), 32'h0);
    step();
    chk("rel_armed", 32'(st[1:0]), 32'h1);
    strb = '0;
    repeat (6) step();

    // Randomized traffic with sporadic resets and clears
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 3) == 0) strb[LSB+k] = ~strb[LSB+k];
      data    = DW'($urandom);
      rd_sel  = 2'($urandom);
      ovf_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end
    strb = '0; ovf_clr = 1'b0;
    repeat (8) step();

    // Single-channel, HOLD_CYC=1 instance with strobe held high
    ndone = 0;
    strb1 = 1'b1; sel1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) begin
        chk("c1_armed", 32'(st1), 32'h1);
        data1 = 8'h77;
      end else data1 = 8'h00;
      chk("c1_done", 32'(done1), 32'(i == 2));
      if (done1 == 1'b1) ndone++;
    end
    chk("c1_count", 32'(ndone), 32'd1);
    chk("c1_selovr", 32'(dout1), 32'h0);
    sel1 = 1'b0; #1;
    chk("c1_data", 32'(dout1), 32'h77);
    chk("c1_ovf", 32'(ovf1), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
